// File: rtl/match_sched_pkg.sv
// Shared types and constants for the two-lane match/priority scheduler.
// Optional statistics counters are enabled with MATCH_SCHED_STATS_EN.
package match_sched_pkg;

   localparam int RULE_ID  = 14;
   localparam int NUM_CAND = 8;
   localparam logic [RULE_ID-1:0] NO_MATCH_ID = '1;

   typedef struct packed {
      logic [NUM_CAND-1:0]              flags;
      logic [NUM_CAND-1:0][RULE_ID-1:0] ids;
   } lane_entry_t;

   typedef struct packed {
      logic               hit;
      logic [RULE_ID-1:0] id;
   } resolve_t;

   // lo must come from the lower slot index so equal IDs keep the lower slot.
   function automatic resolve_t pick_min(input resolve_t lo, input resolve_t hi);
      resolve_t res;
      res = hi;
      if (lo.hit && (!hi.hit || (lo.id <= hi.id))) begin
         res = lo;
      end
      return res;
   endfunction

endpackage

// File: rtl/match_min_tree.sv
// Combinational 8->4->2->1 minimum-ID resolver over one lane entry.
// Unmatched slots never win; no match yields NO_MATCH_ID with hit cleared.
module match_min_tree
   import match_sched_pkg::*;
(
   input  lane_entry_t entry_in,
   output resolve_t    result_out
);

   resolve_t lvl0 [NUM_CAND];
   resolve_t lvl1 [NUM_CAND/2];
   resolve_t lvl2 [NUM_CAND/4];

   always_comb begin
      for (int i = 0; i < NUM_CAND; i++) begin
         lvl0[i].hit = entry_in.flags[i];
         lvl0[i].id  = entry_in.flags[i] ? entry_in.ids[i] : NO_MATCH_ID;
      end
      for (int i = 0; i < NUM_CAND/2; i++) begin
         lvl1[i] = pick_min(lvl0[2*i], lvl0[2*i+1]);
      end
      for (int i = 0; i < NUM_CAND/4; i++) begin
         lvl2[i] = pick_min(lvl1[2*i], lvl1[2*i+1]);
      end
      result_out = pick_min(lvl2[0], lvl2[1]);
   end

endmodule

// File: rtl/match_priority_scheduler.sv
// Two per-lane FIFOs sharing one round-robin priority resolver with a valid/ready output.
// Define MATCH_SCHED_STATS_EN to add saturating hit/miss/drop counters.
module match_priority_scheduler
   import match_sched_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        RST,
   input  logic [NUM_CAND*RULE_ID-1:0] rule_pri_in1,
   input  logic [NUM_CAND*RULE_ID-1:0] rule_pri_in2,
   input  logic [NUM_CAND-1:0]         match_flag_in1,
   input  logic [NUM_CAND-1:0]         match_flag_in2,
   input  logic                        data_valid_in1,
   input  logic                        data_valid_in2,
   output logic [RULE_ID-1:0]          rule_id_out,
   output logic                        hit_out,
   output logic                        lane_out,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        drop_sticky
`ifdef MATCH_SCHED_STATS_EN
   ,
   output logic [31:0]                 hit_cnt,
   output logic [31:0]                 miss_cnt,
   output logic [31:0]                 drop_cnt
`endif
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   lane_entry_t wr_entry  [2];
   logic        wr_valid  [2];
   lane_entry_t head      [2];
   logic        not_empty [2];
   logic        drop      [2];
   logic [1:0]  rd_en;

   assign wr_entry[0] = lane_entry_t'({match_flag_in1, rule_pri_in1});
   assign wr_entry[1] = lane_entry_t'({match_flag_in2, rule_pri_in2});
   assign wr_valid[0] = data_valid_in1;
   assign wr_valid[1] = data_valid_in2;

   for (genvar l = 0; l < 2; l++) begin : g_fifo
      lane_entry_t       mem_q [FIFO_DEPTH];
      lane_entry_t       mem_d [FIFO_DEPTH];
      logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
      logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
      logic [CNT_W-1:0]  count_q, count_d;
      logic              wr_ok;

      // A full FIFO still accepts when its head leaves on the same edge.
      always_comb begin
         mem_d    = mem_q;
         wr_ptr_d = wr_ptr_q;
         rd_ptr_d = rd_ptr_q;
         wr_ok    = wr_valid[l] && ((count_q < CNT_W'(FIFO_DEPTH)) || rd_en[l]);
         if (wr_ok) begin
            mem_d[wr_ptr_q] = wr_entry[l];
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (rd_en[l]) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         count_d = count_q + CNT_W'(wr_ok) - CNT_W'(rd_en[l]);
      end

      always_ff @(posedge clk) begin
         if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
         end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
         end
      end

      always_ff @(posedge clk) begin
         mem_q <= mem_d;
      end

      assign head[l]      = mem_q[rd_ptr_q];
      assign not_empty[l] = (count_q != '0);
      assign drop[l]      = wr_valid[l] && !wr_ok;
   end

   logic               adv;
   logic               any_req;
   logic               grant;
   lane_entry_t        gnt_entry;
   resolve_t           resolved;

   logic               rr_q, rr_d;
   logic               out_valid_q, out_valid_d;
   logic [RULE_ID-1:0] rule_id_q, rule_id_d;
   logic               hit_q, hit_d;
   logic               lane_q, lane_d;
   logic               drop_sticky_q, drop_sticky_d;

   assign gnt_entry = grant ? head[1] : head[0];

   match_min_tree u_min_tree (
      .entry_in   (gnt_entry),
      .result_out (resolved)
   );

   always_comb begin
      adv     = !out_valid_q || out_ready;
      any_req = not_empty[0] || not_empty[1];
      if (not_empty[0] && not_empty[1]) begin
         grant = rr_q;
      end else begin
         grant = !not_empty[0];
      end

      rd_en         = '0;
      rr_d          = rr_q;
      out_valid_d   = out_valid_q;
      rule_id_d     = rule_id_q;
      hit_d         = hit_q;
      lane_d        = lane_q;
      drop_sticky_d = drop_sticky_q | drop[0] | drop[1];

      // Output register only moves when empty or being consumed.
      if (adv) begin
         out_valid_d = any_req;
         if (any_req) begin
            rd_en[grant] = 1'b1;
            rule_id_d    = resolved.id;
            hit_d        = resolved.hit;
            lane_d       = grant;
            rr_d         = !grant;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         rr_q          <= 1'b0;
         out_valid_q   <= 1'b0;
         rule_id_q     <= '0;
         hit_q         <= 1'b0;
         lane_q        <= 1'b0;
         drop_sticky_q <= 1'b0;
      end else begin
         rr_q          <= rr_d;
         out_valid_q   <= out_valid_d;
         rule_id_q     <= rule_id_d;
         hit_q         <= hit_d;
         lane_q        <= lane_d;
         drop_sticky_q <= drop_sticky_d;
      end
   end

   assign rule_id_out = rule_id_q;
   assign hit_out     = hit_q;
   assign lane_out    = lane_q;
   assign out_valid   = out_valid_q;
   assign drop_sticky = drop_sticky_q;

`ifdef MATCH_SCHED_STATS_EN
   logic [31:0] hit_cnt_q, hit_cnt_d;
   logic [31:0] miss_cnt_q, miss_cnt_d;
   logic [31:0] drop_cnt_q, drop_cnt_d;
   logic [32:0] drop_sum;

   always_comb begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if (out_valid_q && out_ready) begin
         if (hit_q) begin
            hit_cnt_d = (hit_cnt_q == '1) ? hit_cnt_q : hit_cnt_q + 32'd1;
         end else begin
            miss_cnt_d = (miss_cnt_q == '1) ? miss_cnt_q : miss_cnt_q + 32'd1;
         end
      end
      drop_sum   = {1'b0, drop_cnt_q} + 33'(drop[0]) + 33'(drop[1]);
      drop_cnt_d = drop_sum[32] ? '1 : drop_sum[31:0];
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
         drop_cnt_q <= '0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign hit_cnt  = hit_cnt_q;
   assign miss_cnt = miss_cnt_q;
   assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_match_priority_scheduler.sv
// Directed and randomized bench for match_priority_scheduler against a queue-based reference model.
// Statistics outputs are checked when MATCH_SCHED_STATS_EN is defined.
module tb_match_priority_scheduler;

   localparam int W     = 14;
   localparam int NC    = 8;
   localparam int DEPTH = 4;

   typedef logic [NC+NC*W-1:0] pkt_t;

   logic           clk;
   logic           RST;
   logic [NC*W-1:0] rule_pri_in1, rule_pri_in2;
   logic [NC-1:0]  match_flag_in1, match_flag_in2;
   logic           data_valid_in1, data_valid_in2;
   logic [W-1:0]   rule_id_out;
   logic           hit_out, lane_out, out_valid, out_ready, drop_sticky;
   logic [31:0]    hit_cnt, miss_cnt, drop_cnt;

   int checks = 0;
   int errors = 0;

   match_priority_scheduler #(.FIFO_DEPTH(DEPTH)) dut (
      .clk            (clk),
      .RST            (RST),
      .rule_pri_in1   (rule_pri_in1),
      .rule_pri_in2   (rule_pri_in2),
      .match_flag_in1 (match_flag_in1),
      .match_flag_in2 (match_flag_in2),
      .data_valid_in1 (data_valid_in1),
      .data_valid_in2 (data_valid_in2),
      .rule_id_out    (rule_id_out),
      .hit_out        (hit_out),
      .lane_out       (lane_out),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .drop_sticky    (drop_sticky)
`ifdef MATCH_SCHED_STATS_EN
      ,
      .hit_cnt        (hit_cnt),
      .miss_cnt       (miss_cnt),
      .drop_cnt       (drop_cnt)
`endif
   );

`ifndef MATCH_SCHED_STATS_EN
   assign hit_cnt  = '0;
   assign miss_cnt = '0;
   assign drop_cnt = '0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: per-lane packet queues plus the visible output register.
   pkt_t         q0[$], q1[$];
   logic         m_valid, m_hit, m_lane, m_rr, m_sticky;
   logic [W-1:0] m_id;
   logic [31:0]  m_hitc, m_missc, m_dropc;

   function automatic logic [W:0] resolve(input pkt_t p);
      logic         hit;
      logic [W-1:0] best;
      logic [W-1:0] id;
      hit  = 1'b0;
      best = '1;
      for (int i = 0; i < NC; i++) begin
         id = p[i*W +: W];
         if (p[NC*W + i] && (!hit || id < best)) begin
            hit  = 1'b1;
            best = id;
         end
      end
      return {hit, best};
   endfunction

   function automatic logic [31:0] sat_add(input logic [31:0] a, input int n);
      longint s;
      s = longint'(a) + longint'(n);
      return (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
   endfunction

   task automatic model_edge();
      logic       adv, got, g;
      logic [W:0] r;
      pkt_t       p;
      if (RST) begin
         q0.delete();
         q1.delete();
         m_valid = 0; m_hit = 0; m_lane = 0; m_rr = 0; m_sticky = 0; m_id = '0;
         m_hitc = '0; m_missc = '0; m_dropc = '0;
         return;
      end
      adv = !m_valid || out_ready;
      if (m_valid && out_ready) begin
         if (m_hit) m_hitc = sat_add(m_hitc, 1);
         else       m_missc = sat_add(m_missc, 1);
      end
      got = 0;
      g   = 0;
      if (adv) begin
         if (q0.size() > 0 && q1.size() > 0) begin got = 1; g = m_rr; end
         else if (q0.size() > 0)             begin got = 1; g = 0;    end
         else if (q1.size() > 0)             begin got = 1; g = 1;    end
      end
      if (got) begin
         p = g ? q1.pop_front() : q0.pop_front();
         r = resolve(p);
         m_valid = 1;
         m_hit   = r[W];
         m_id    = r[W-1:0];
         m_lane  = g;
         m_rr    = !g;
      end else if (adv) begin
         m_valid = 0;
      end
      if (data_valid_in1) begin
         if (q0.size() < DEPTH) q0.push_back({match_flag_in1, rule_pri_in1});
         else begin m_sticky = 1; m_dropc = sat_add(m_dropc, 1); end
      end
      if (data_valid_in2) begin
         if (q1.size() < DEPTH) q1.push_back({match_flag_in2, rule_pri_in2});
         else begin m_sticky = 1; m_dropc = sat_add(m_dropc, 1); end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("rule_id_out", 32'(rule_id_out), 32'(m_id));
      chk("hit_out", 32'(hit_out), 32'(m_hit));
      chk("lane_out", 32'(lane_out), 32'(m_lane));
      chk("drop_sticky", 32'(drop_sticky), 32'(m_sticky));
`ifdef MATCH_SCHED_STATS_EN
      chk("hit_cnt", hit_cnt, m_hitc);
      chk("miss_cnt", miss_cnt, m_missc);
      chk("drop_cnt", drop_cnt, m_dropc);
`endif
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic rand_pkt(output logic [NC*W-1:0] pri, output logic [NC-1:0] flags);
      for (int i = 0; i < NC; i++) begin
         pri[i*W +: W] = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 15));
      end
      flags = ($urandom_range(0, 7) == 0) ? '0 : NC'($urandom);
   endtask

   task automatic idle();
      data_valid_in1 = 0;
      data_valid_in2 = 0;
   endtask

   int           seq[$];
   int           results;
   logic [W-1:0] held;
   logic         held_set;

   initial begin
      RST = 1; out_ready = 1;
      data_valid_in1 = 0; data_valid_in2 = 0;
      rule_pri_in1 = '0; rule_pri_in2 = '0; match_flag_in1 = '0; match_flag_in2 = '0;
      step();
      step();
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_id", 32'(rule_id_out), 32'd0);
      chk("rst_sticky", 32'(drop_sticky), 32'd0);
      RST = 0;
      step();

      // Single lane-1 packet: slot2=37, slot5=12 matched.
      rand_pkt(rule_pri_in1, match_flag_in1);
      rule_pri_in1[2*W +: W] = 14'd37;
      rule_pri_in1[5*W +: W] = 14'd12;
      match_flag_in1 = 8'b0010_0100;
      data_valid_in1 = 1;
      step();
      idle();
      chk("single_cycle1_valid", 32'(out_valid), 32'd0);
      step();
      chk("single_valid", 32'(out_valid), 32'd1);
      chk("single_id", 32'(rule_id_out), 32'd12);
      chk("single_hit", 32'(hit_out), 32'd1);
      chk("single_lane", 32'(lane_out), 32'd0);

      // Lane-2 packet with no matches.
      rand_pkt(rule_pri_in2, match_flag_in2);
      match_flag_in2 = '0;
      data_valid_in2 = 1;
      step();
      idle();
      step();
      chk("miss_valid", 32'(out_valid), 32'd1);
      chk("miss_hit", 32'(hit_out), 32'd0);
      chk("miss_id", 32'(rule_id_out), 32'h3FFF);
      chk("miss_lane", 32'(lane_out), 32'd1);
      step();
`ifdef MATCH_SCHED_STATS_EN
      chk("miss_cnt_one", miss_cnt, 32'd1);
`endif

      // Both lanes every cycle for three cycles: lanes must alternate.
      seq.delete();
      for (int c = 0; c < 9; c++) begin
         if (c < 3) begin
            rand_pkt(rule_pri_in1, match_flag_in1);
            rand_pkt(rule_pri_in2, match_flag_in2);
            data_valid_in1 = 1;
            data_valid_in2 = 1;
         end else begin
            idle();
         end
         step();
         if (out_valid) seq.push_back(int'(lane_out));
      end
      chk("alt_count", 32'(seq.size()), 32'd6);
      for (int i = 0; i < seq.size(); i++) chk("alt_lane", 32'(seq[i]), 32'(i % 2));
      chk("alt_no_drop", 32'(drop_sticky), 32'd0);

      // Tie between slot1 and slot6.
      rand_pkt(rule_pri_in1, match_flag_in1);
      match_flag_in1 = 8'b0100_1010;
      rule_pri_in1[1*W +: W] = 14'd9;
      rule_pri_in1[3*W +: W] = 14'd20;
      rule_pri_in1[6*W +: W] = 14'd9;
      data_valid_in1 = 1;
      step();
      idle();
      step();
      chk("tie_id", 32'(rule_id_out), 32'd9);
      chk("tie_hit", 32'(hit_out), 32'd1);
      step();

      // Backpressure: 10 lane-1 packets with out_ready low.
      out_ready = 0;
      held_set  = 0;
      held      = '0;
      for (int c = 0; c < 10; c++) begin
         rand_pkt(rule_pri_in1, match_flag_in1);
         data_valid_in1 = 1;
         step();
         if (held_set) chk("bp_held_id", 32'(rule_id_out), 32'(held));
         if (out_valid && !held_set) begin
            held     = rule_id_out;
            held_set = 1;
         end
      end
      idle();
      chk("bp_held_valid", 32'(out_valid), 32'd1);
      chk("bp_sticky", 32'(drop_sticky), 32'd1);
`ifdef MATCH_SCHED_STATS_EN
      chk("bp_drop_cnt", drop_cnt, 32'd5);
`endif
      out_ready = 1;
      results   = 0;
      for (int c = 0; c < 10; c++) begin
         if (out_valid) results++;
         step();
      end
      chk("bp_results", 32'(results), 32'd5);

      // Reset while output valid and FIFOs hold data.
      out_ready = 0;
      for (int c = 0; c < 3; c++) begin
         rand_pkt(rule_pri_in1, match_flag_in1);
         rand_pkt(rule_pri_in2, match_flag_in2);
         data_valid_in1 = 1;
         data_valid_in2 = 1;
         step();
      end
      chk("pre_rst_valid", 32'(out_valid), 32'd1);
      RST = 1;
      step();
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      RST = 0;
      idle();
      out_ready = 1;
      for (int c = 0; c < 4; c++) begin
         step();
         chk("post_rst_no_stale", 32'(out_valid), 32'd0);
      end

      // Randomized traffic with occasional resets.
      for (int c = 0; c < 3000; c++) begin
         RST = ($urandom_range(0, 299) == 0);
         rand_pkt(rule_pri_in1, match_flag_in1);
         rand_pkt(rule_pri_in2, match_flag_in2);
         data_valid_in1 = ($urandom_range(0, 99) < 45);
         data_valid_in2 = ($urandom_range(0, 99) < 45);
         out_ready      = ($urandom_range(0, 99) < 75);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
